// File: rtl/flow_input_pkg.sv
// Shared constants and types for the board push-button input path.
// Default timing targets the 50 MHz board clock.
package flow_input_pkg;

   localparam int DEBOUNCE_CYCLES_50MHZ = 500000;
   localparam int REPEAT_DELAY_50MHZ    = 25000000;
   localparam int REPEAT_PERIOD_50MHZ   = 5000000;

   localparam int KEY_RESET      = 0;
   localparam int KEY_LOAD       = 1;
   localparam int KEY_USER_CLK   = 2;
   localparam int KEY_SWITCH_CLK = 3;

   typedef enum logic {
      RELEASED = 1'b0,
      HELD     = 1'b1
   } key_state_e;

   // Bits needed for a counter that runs 0 .. v-1.
   function automatic int cnt_width(input int v);
      return (v < 2) ? 1 : $clog2(v);
   endfunction

endpackage

// File: rtl/key_conditioner_debounce_channel.sv
// One button: 2-flop synchroniser, stability debounce, press/release pulses.
// Auto-repeat on press when KEY_CONDITIONER_AUTO_REPEAT_EN is defined.
module debounce_channel
   import flow_input_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
   parameter int CNT_W           = 20
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
   ,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_50MHZ,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_50MHZ
`endif
) (
   input  logic clock,
   input  logic resetn,
   input  logic key_n,
   output logic level,
   output logic press,
   output logic release_pulse
);

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic sync_a;
   logic sync_b;
   logic sampled;

   key_state_e state;
   key_state_e state_d;

   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_d;

   logic accept_press;
   logic accept_release;
   logic press_d;

   // Idle-high pins: reset the synchroniser to "released".
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         sync_a <= 1'b1;
         sync_b <= 1'b1;
      end else begin
         sync_a <= key_n;
         sync_b <= sync_a;
      end
   end

   assign sampled = ~sync_b;
   assign level   = (state == HELD);

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state <= RELEASED;
         cnt   <= '0;
      end else begin
         state <= state_d;
         cnt   <= cnt_d;
      end
   end

   always_comb begin
      state_d        = state;
      cnt_d          = '0;
      accept_press   = 1'b0;
      accept_release = 1'b0;
      if (sampled != level) begin
         if (cnt == CNT_LAST) begin
            unique case (state)
               RELEASED: begin
                  state_d      = HELD;
                  accept_press = 1'b1;
               end
               HELD: begin
                  state_d        = RELEASED;
                  accept_release = 1'b1;
               end
               default: state_d = RELEASED;
            endcase
         end else begin
            cnt_d = cnt + 1'b1;
         end
      end
   end

`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
   localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ?
                            REPEAT_DELAY : REPEAT_PERIOD;
   localparam int RPT_W   = cnt_width(RPT_MAX);
   localparam logic [RPT_W-1:0] DELAY_LAST  = RPT_W'(REPEAT_DELAY - 1);
   localparam logic [RPT_W-1:0] PERIOD_LAST = RPT_W'(REPEAT_PERIOD - 1);

   logic [RPT_W-1:0] rpt_cnt;
   logic [RPT_W-1:0] rpt_cnt_d;
   logic             rpt_phase;
   logic             rpt_phase_d;
   logic             rpt_fire;

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         rpt_cnt   <= '0;
         rpt_phase <= 1'b0;
      end else begin
         rpt_cnt   <= rpt_cnt_d;
         rpt_phase <= rpt_phase_d;
      end
   end

   // rpt_phase: 0 = waiting out the initial delay, 1 = periodic repeats.
   always_comb begin
      rpt_cnt_d   = '0;
      rpt_phase_d = 1'b0;
      rpt_fire    = 1'b0;
      if (state == HELD && !accept_release) begin
         rpt_phase_d = rpt_phase;
         if (!rpt_phase) begin
            if (rpt_cnt == DELAY_LAST) begin
               rpt_fire    = 1'b1;
               rpt_phase_d = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt + 1'b1;
            end
         end else begin
            if (rpt_cnt == PERIOD_LAST) begin
               rpt_fire = 1'b1;
            end else begin
               rpt_cnt_d = rpt_cnt + 1'b1;
            end
         end
      end
   end

   assign press_d = accept_press | rpt_fire;
`else
   assign press_d = accept_press;
`endif

   // Pulses line up with the first cycle of the new level.
   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         press         <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press         <= press_d;
         release_pulse <= accept_release;
      end
   end

endmodule

// File: rtl/key_conditioner.sv
// Debounces NUM_KEYS active-low board buttons into levels and strobes.
// Optional auto-repeat: KEY_CONDITIONER_AUTO_REPEAT_EN.
module key_conditioner
   import flow_input_pkg::*;
#(
   parameter int NUM_KEYS        = 4,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_50MHZ,
   parameter int CNT_W           = 20,
   parameter int REPEAT_DELAY    = REPEAT_DELAY_50MHZ,
   parameter int REPEAT_PERIOD   = REPEAT_PERIOD_50MHZ
) (
   input  logic                clock,
   input  logic                resetn,
   input  logic [NUM_KEYS-1:0] key_n,
   output logic [NUM_KEYS-1:0] level,
   output logic [NUM_KEYS-1:0] press,
   output logic [NUM_KEYS-1:0] release_pulse
);

   localparam longint CNT_CAP = (64'd1 << CNT_W) - 64'd1;

   if (DEBOUNCE_CYCLES < 2 || longint'(DEBOUNCE_CYCLES) > CNT_CAP)
   begin : g_bad_debounce
      $error("DEBOUNCE_CYCLES outside 2..2^CNT_W-1");
   end

   if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_repeat
      $error("REPEAT_DELAY and REPEAT_PERIOD must be positive");
   end

   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_chan
      debounce_channel #(
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .CNT_W           (CNT_W)
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
         ,
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_PERIOD   (REPEAT_PERIOD)
`endif
      ) u_chan (
         .clock         (clock),
         .resetn        (resetn),
         .key_n         (key_n[k]),
         .level         (level[k]),
         .press         (press[k]),
         .release_pulse (release_pulse[k])
      );
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: per-cycle model compare
// plus hand-computed pulse timing and counts.
module tb_key_conditioner;

   localparam int NK  = 4;
   localparam int DEB = 4;
   localparam int RD  = 10;
   localparam int RP  = 5;

   logic          clock  = 1'b0;
   logic          resetn = 1'b1;
   logic [NK-1:0] key_n  = '1;
   logic [NK-1:0] level;
   logic [NK-1:0] press;
   logic [NK-1:0] release_pulse;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;
   bit cmp_on = 1'b0;

   key_conditioner #(
      .NUM_KEYS        (NK),
      .DEBOUNCE_CYCLES (DEB),
      .CNT_W           (20),
      .REPEAT_DELAY    (RD),
      .REPEAT_PERIOD   (RP)
   ) dut (
      .clock         (clock),
      .resetn        (resetn),
      .key_n         (key_n),
      .level         (level),
      .press         (press),
      .release_pulse (release_pulse)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  name, act, exp, cyc);
      end
   endtask

   // Model: pins reach the decision point two edges late; a new level is
   // accepted after DEB consecutive disagreeing samples.
   logic [NK-1:0] m_level   = '0;
   logic [NK-1:0] m_press   = '0;
   logic [NK-1:0] m_release = '0;
   logic [NK-1:0] pin_d1    = '1;
   logic [NK-1:0] pin_d2    = '1;
   int            streak[NK];
   int            held_age[NK];

   always @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         m_level   = '0;
         m_press   = '0;
         m_release = '0;
         pin_d1    = '1;
         pin_d2    = '1;
         for (int i = 0; i < NK; i++) begin
            streak[i]   = 0;
            held_age[i] = 0;
         end
      end else begin
         for (int i = 0; i < NK; i++) begin
            logic want;
            want         = ~pin_d2[i];
            m_press[i]   = 1'b0;
            m_release[i] = 1'b0;
            if (want == m_level[i]) begin
               streak[i] = 0;
            end else if (streak[i] + 1 >= DEB) begin
               m_level[i]  = want;
               streak[i]   = 0;
               held_age[i] = 0;
               if (want) m_press[i] = 1'b1;
               else      m_release[i] = 1'b1;
            end else begin
               streak[i]++;
            end
`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
            if (m_level[i] && !m_press[i]) begin
               held_age[i]++;
               if (held_age[i] == RD ||
                   (held_age[i] > RD && (held_age[i] - RD) % RP == 0))
                  m_press[i] = 1'b1;
            end
`endif
         end
         pin_d2 = pin_d1;
         pin_d1 = key_n;
      end
   end

   int p_cnt[NK];
   int r_cnt[NK];
   int p_at[NK];
   int r_at[NK];

   initial begin
      for (int i = 0; i < NK; i++) begin
         p_cnt[i] = 0;
         r_cnt[i] = 0;
         p_at[i]  = 0;
         r_at[i]  = 0;
      end
   end

   always @(negedge clock) begin
      if (cmp_on) begin
         check("cycle_outputs", {20'd0, level, press, release_pulse},
               {20'd0, m_level, m_press, m_release});
         for (int i = 0; i < NK; i++) begin
            if (press[i]) begin
               p_cnt[i]++;
               p_at[i] = cyc;
            end
            if (release_pulse[i]) begin
               r_cnt[i]++;
               r_at[i] = cyc;
            end
         end
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   int bp[NK];
   int br[NK];
   int t0;

   task automatic snap();
      for (int i = 0; i < NK; i++) begin
         bp[i] = p_cnt[i];
         br[i] = r_cnt[i];
      end
   endtask

   initial begin
      #1 resetn = 1'b0;
      cmp_on = 1'b1;
      tick(3);
      check("reset_outputs", {20'd0, level, press, release_pulse}, 32'd0);
      resetn = 1'b1;
      tick(50);
      check("idle_level", {28'd0, level}, 32'd0);
      check("idle_press_cnt", p_cnt[0] + p_cnt[1] + p_cnt[2] + p_cnt[3], 0);

      // Clean press / release on key 2.
      snap();
      t0 = cyc;
      key_n[2] = 1'b0;
      tick(10);
      check("k2_press_cnt", p_cnt[2] - bp[2], 1);
      check("k2_press_lat", p_at[2] - t0, 6);
      check("k2_level", {31'd0, level[2]}, 1);
      check("k2_no_release", r_cnt[2] - br[2], 0);
      t0 = cyc;
      key_n[2] = 1'b1;
      tick(10);
      check("k2_release_cnt", r_cnt[2] - br[2], 1);
      check("k2_release_lat", r_at[2] - t0, 6);

      // Bouncing press on key 1.
      snap();
      key_n[1] = 1'b0; tick(1);
      key_n[1] = 1'b1; tick(1);
      key_n[1] = 1'b0; tick(1);
      key_n[1] = 1'b1; tick(1);
      key_n[1] = 1'b0;
      t0 = cyc;
      tick(12);
      check("k1_bounce_press_cnt", p_cnt[1] - bp[1], 1);
      check("k1_bounce_lat", p_at[1] - t0, 6);
      check("k1_bounce_no_rel", r_cnt[1] - br[1], 0);
      key_n[1] = 1'b1;
      tick(10);

      // Short glitch on key 3.
      snap();
      key_n[3] = 1'b0;
      tick(3);
      key_n[3] = 1'b1;
      tick(15);
      check("k3_glitch_press", p_cnt[3] - bp[3], 0);
      check("k3_glitch_rel", r_cnt[3] - br[3], 0);
      check("k3_glitch_level", {31'd0, level[3]}, 0);

      // Simultaneous keys 1 and 2.
      snap();
      t0 = cyc;
      key_n[2:1] = 2'b00;
      tick(20);
      check("dual_press_k1", p_cnt[1] - bp[1], 1);
      check("dual_press_k2", p_cnt[2] - bp[2], 1);
      check("dual_press_k1_at", p_at[1] - t0, 6);
      check("dual_press_k2_at", p_at[2] - t0, 6);
      t0 = cyc;
      key_n[2:1] = 2'b11;
      tick(12);
      check("dual_rel_k1", r_cnt[1] - br[1], 1);
      check("dual_rel_k2", r_cnt[2] - br[2], 1);
      check("dual_rel_k1_at", r_at[1] - t0, 6);
      check("dual_rel_k2_at", r_at[2] - t0, 6);

      // Reset in the middle of a debounce window.
      snap();
      key_n[0] = 1'b0;
      tick(4);
      #3 resetn = 1'b0;
      #1;
      check("mid_deb_reset_out", {20'd0, level, press, release_pulse}, 0);
      tick(2);
      key_n[0] = 1'b1;
      resetn = 1'b1;
      tick(12);
      check("mid_deb_no_press", p_cnt[0] - bp[0], 0);

`ifdef KEY_CONDITIONER_AUTO_REPEAT_EN
      // Auto-repeat on key 0: pulses at +0,10,15,...,45; release at +46.
      snap();
      t0 = cyc;
      key_n[0] = 1'b0;
      tick(6);
      check("rpt_first_at", p_at[0] - t0, 6);
      t0 = t0 + 6;
      tick(36);
      check("rpt_cnt_36", p_cnt[0] - bp[0], 7);
      check("rpt_last_at", p_at[0] - t0, 35);
      tick(4);
      key_n[0] = 1'b1;
      tick(20);
      check("rpt_cnt_final", p_cnt[0] - bp[0], 9);
      check("rpt_rel_cnt", r_cnt[0] - br[0], 1);
      check("rpt_rel_at", r_at[0] - t0, 46);

      // Reset while held with repeat running.
      key_n[0] = 1'b0;
      tick(20);
      #3 resetn = 1'b0;
      #1;
      check("rpt_reset_out", {20'd0, level, press, release_pulse}, 0);
      tick(2);
      key_n[0] = 1'b1;
      resetn = 1'b1;
      tick(10);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
